// File: rtl/pid_loop_scheduler.sv
// pid_loop_scheduler
// Host-side sequencer for the kf_top PID micro-core. It issues START, primes
// the core with zero words, then streams Kp, Ki, Kd, setpoint and measurement
// once per control loop. When the core PC reaches END_PC, it captures the PID
// output from the core data bank and presents it with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   enable          level, 1 = run the scheduler
//   sample_req      1-cycle strobe, latch setpoint/meas into the staging entry
//   setpoint, meas  sign-magnitude sample inputs
//   kp, ki, kd      gains, sampled at the first word of every LOAD
//   core_pc         core sequencer program counter
//   core_data_out   core combinational read of bank[core_dir]
//   core_start      1-cycle START pulse to the core
//   core_data_in    operand word to the core
//   core_dir        bank read address (OUT_ADDR while RUN, else 0)
//   result          last captured PID output
//   result_valid    1-cycle pulse, result updated
//   stale           1 = last loop reused the previous sample
//   err_timeout     sticky timeout flag, cleared by enable=0 or reset
//   overrun         sticky, a staged sample was overwritten before use
module pid_loop_scheduler #(
   parameter int W        = 24,
   parameter int ADDRW    = 5,
   parameter int PCW      = 8,
   parameter int END_PC   = 27,
   parameter int OUT_ADDR = 8,
   parameter int PRIME_N  = 2,
   parameter int TIMEOUT  = 300
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sample_req,
   input  logic [W-1:0]     setpoint,
   input  logic [W-1:0]     meas,
   input  logic [W-1:0]     kp,
   input  logic [W-1:0]     ki,
   input  logic [W-1:0]     kd,
   input  logic [PCW-1:0]   core_pc,
   input  logic [W-1:0]     core_data_out,
   output logic             core_start,
   output logic [W-1:0]     core_data_in,
   output logic [ADDRW-1:0] core_dir,
   output logic [W-1:0]     result,
   output logic             result_valid,
   output logic             stale,
   output logic             err_timeout,
   output logic             overrun
);

   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam int CNTW = (TW > 3) ? TW : 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PRIME,
      S_LOAD,
      S_RUN,
      S_FAULT
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CNTW-1:0] cnt;
   logic [W-1:0]    ki_q;
   logic [W-1:0]    kd_q;
   logic [W-1:0]    held_sp;
   logic [W-1:0]    held_ms;
   logic            stg_valid;
   logic [W-1:0]    stg_sp;
   logic [W-1:0]    stg_ms;
   logic            end_hit;
   logic            word0;
   logic            consume;

   assign end_hit = (state_q == S_RUN) && (core_pc == PCW'(END_PC));
   assign word0   = (state_q == S_LOAD) && (cnt == '0);
   assign consume = word0 && stg_valid;

   // State register. Reset drops straight back to IDLE, so START is only
   // reissued once enable is seen high again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Enable is only looked at in IDLE, at loop end and in
   // FAULT, so a loop that is already underway always runs through capture
   // before the scheduler parks.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_START;
         end
         S_START: begin
            state_d = S_PRIME;
         end
         S_PRIME: begin
            if (cnt == CNTW'(PRIME_N - 1)) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (cnt == CNTW'(4)) state_d = S_RUN;
         end
         S_RUN: begin
            if (end_hit) begin
               state_d = enable ? S_LOAD : S_IDLE;
            end else if (cnt == CNTW'(TIMEOUT)) begin
               state_d = S_FAULT;
            end
         end
         S_FAULT: begin
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode. Word 0 forwards kp live because the gains are sampled on
   // that very cycle. The later words come from the registers loaded at that
   // same edge.
   always_comb begin
      core_start   = 1'b0;
      core_data_in = '0;
      core_dir     = '0;
      case (state_q)
         S_START: core_start = 1'b1;
         S_LOAD: begin
            case (cnt)
               CNTW'(0): core_data_in = kp;
               CNTW'(1): core_data_in = ki_q;
               CNTW'(2): core_data_in = kd_q;
               CNTW'(3): core_data_in = held_sp;
               CNTW'(4): core_data_in = held_ms;
               default:  core_data_in = '0;
            endcase
         end
         S_RUN:   core_dir = ADDRW'(OUT_ADDR);
         default: ;
      endcase
   end

   // Shared phase counter. It restarts on every state change and counts the
   // prime words, the load word index and the RUN cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_d != state_q) begin
         cnt <= '0;
      end else if (state_q == S_PRIME || state_q == S_LOAD || state_q == S_RUN) begin
         cnt <= cnt + CNTW'(1);
      end
   end

   // Gain and sample capture at LOAD word 0. A fresh staged sample becomes
   // the held sample. Otherwise the held sample is resent and flagged stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ki_q    <= '0;
         kd_q    <= '0;
         held_sp <= '0;
         held_ms <= '0;
         stale   <= 1'b0;
      end else if (word0) begin
         ki_q  <= ki;
         kd_q  <= kd;
         stale <= !stg_valid;
         if (stg_valid) begin
            held_sp <= stg_sp;
            held_ms <= stg_ms;
         end
      end
   end

   // One-entry staging buffer. A request on the consumption cycle refills the
   // entry that is being drained, so it does not count as an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_valid <= 1'b0;
         stg_sp    <= '0;
         stg_ms    <= '0;
      end else if (sample_req) begin
         stg_valid <= 1'b1;
         stg_sp    <= setpoint;
         stg_ms    <= meas;
      end else if (consume) begin
         stg_valid <= 1'b0;
      end
   end

   // Result capture on the edge that sees END_PC. The valid pulse lines up
   // with Kp going out for the next loop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= end_hit;
         if (end_hit) result <= core_data_out;
      end
   end

   // Sticky status flags. Setting takes priority, and dropping enable clears
   // them. This is how FAULT is acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (state_d == S_FAULT) begin
            err_timeout <= 1'b1;
         end else if (!enable) begin
            err_timeout <= 1'b0;
         end
         if (sample_req && stg_valid && !consume) begin
            overrun <= 1'b1;
         end else if (!enable) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// tb_pid_loop_scheduler
// Directed bench for pid_loop_scheduler. It drives the core PC and data bank
// directly and walks through start-up, normal loops, stale and overrun
// handling, timeout, asynchronous reset and the enable drain.
module tb_pid_loop_scheduler;

   localparam int          W      = 24;
   localparam logic [23:0] KP     = 24'h000290;
   localparam logic [23:0] KI     = 24'h0000A4;
   localparam logic [23:0] KD     = 24'h000000;
   localparam logic [23:0] SP     = 24'h03E000;
   localparam logic [7:0]  ENDPC  = 8'd27;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          sample_req;
   logic [W-1:0]  setpoint;
   logic [W-1:0]  meas;
   logic [W-1:0]  kp;
   logic [W-1:0]  ki;
   logic [W-1:0]  kd;
   logic [7:0]    core_pc;
   logic [W-1:0]  core_data_out;
   logic          core_start;
   logic [W-1:0]  core_data_in;
   logic [4:0]    core_dir;
   logic [W-1:0]  result;
   logic          result_valid;
   logic          stale;
   logic          err_timeout;
   logic          overrun;

   int checks   = 0;
   int failures = 0;

   pid_loop_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .sample_req    (sample_req),
      .setpoint      (setpoint),
      .meas          (meas),
      .kp            (kp),
      .ki            (ki),
      .kd            (kd),
      .core_pc       (core_pc),
      .core_data_out (core_data_out),
      .core_start    (core_start),
      .core_data_in  (core_data_in),
      .core_dir      (core_dir),
      .result        (result),
      .result_valid  (result_valid),
      .stale         (stale),
      .err_timeout   (err_timeout),
      .overrun       (overrun)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever loses its way
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 2 ns after the rising edge
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // One-cycle sample request strobe
   task automatic applyStimulus(input logic [W-1:0] sp, input logic [W-1:0] ms);
      sample_req = 1'b1;
      setpoint   = sp;
      meas       = ms;
      tick;
      sample_req = 1'b0;
   endtask

   // Entered at LOAD word 0 and left at RUN cycle 0. It can optionally fire a
   // sample request on the word-0 cycle.
   task automatic loadWords(input string tag, input logic [W-1:0] expSp, input logic [W-1:0] expMs,
                            input logic expStale, input logic doReq, input logic [W-1:0] reqMs);
      checkOutput({tag, "_w0_kp"}, core_data_in, KP);
      if (doReq) begin
         sample_req = 1'b1;
         setpoint   = SP;
         meas       = reqMs;
      end
      tick;
      sample_req = 1'b0;
      checkOutput({tag, "_w1_ki"}, core_data_in, KI);
      checkOutput({tag, "_stale"}, stale, expStale);
      checkOutput({tag, "_rv_low"}, result_valid, 1'b0);
      tick;
      checkOutput({tag, "_w2_kd"}, core_data_in, KD);
      tick;
      checkOutput({tag, "_w3_sp"}, core_data_in, expSp);
      tick;
      checkOutput({tag, "_w4_ms"}, core_data_in, expMs);
      tick;
      checkOutput({tag, "_run_zero"}, core_data_in, 24'h0);
      checkOutput({tag, "_run_dir"}, core_dir, 5'd8);
   endtask

   // Wait n RUN cycles, then present END_PC with a result in the bank
   task automatic runLoop(input string tag, input int n, input logic [W-1:0] val, input logic expLoad);
      for (int i = 0; i < n; i++) tick;
      checkOutput({tag, "_rv_pre"}, result_valid, 1'b0);
      core_pc       = ENDPC;
      core_data_out = val;
      tick;
      core_pc       = 8'd0;
      core_data_out = 24'h0;
      checkOutput({tag, "_result"}, result, val);
      checkOutput({tag, "_rv"}, result_valid, 1'b1);
      checkOutput({tag, "_next_word"}, core_data_in, expLoad ? KP : 24'h0);
   endtask

   // Directed sequence
   initial begin
      rst_n         = 1'b0;
      enable        = 1'b0;
      sample_req    = 1'b0;
      setpoint      = '0;
      meas          = '0;
      kp            = KP;
      ki            = KI;
      kd            = KD;
      core_pc       = 8'd0;
      core_data_out = '0;
      tick;
      tick;

      checkOutput("rst_start", core_start, 1'b0);
      checkOutput("rst_data", core_data_in, 24'h0);
      checkOutput("rst_dir", core_dir, 5'd0);
      checkOutput("rst_result", result, 24'h0);
      checkOutput("rst_rv", result_valid, 1'b0);
      checkOutput("rst_flags", {stale, err_timeout, overrun}, 3'b000);

      rst_n = 1'b1;
      tick;
      applyStimulus(SP, 24'h000000);
      enable = 1'b1;
      tick;
      checkOutput("start_pulse", core_start, 1'b1);
      checkOutput("start_data", core_data_in, 24'h0);
      tick;
      checkOutput("prime0_start", core_start, 1'b0);
      checkOutput("prime0_data", core_data_in, 24'h0);
      tick;
      checkOutput("prime1_data", core_data_in, 24'h0);
      tick;

      loadWords("L1", SP, 24'h000000, 1'b0, 1'b0, 24'h0);
      runLoop("R1", 3, 24'h004000, 1'b1);

      loadWords("L2", SP, 24'h000000, 1'b1, 1'b0, 24'h0);
      applyStimulus(SP, 24'h000500);
      runLoop("R2", 2, 24'h004100, 1'b1);

      loadWords("L3", SP, 24'h000500, 1'b0, 1'b1, 24'h000700);
      checkOutput("L3_no_overrun", overrun, 1'b0);
      runLoop("R3", 3, 24'h004200, 1'b1);

      loadWords("L4", SP, 24'h000700, 1'b0, 1'b0, 24'h0);
      applyStimulus(SP, 24'h001000);
      checkOutput("ovr_first", overrun, 1'b0);
      applyStimulus(SP, 24'h002000);
      checkOutput("ovr_second", overrun, 1'b1);
      runLoop("R4", 1, 24'h004300, 1'b1);

      loadWords("L5", SP, 24'h002000, 1'b0, 1'b0, 24'h0);
      for (int k = 1; k <= 300; k++) tick;
      checkOutput("to_c300_err", err_timeout, 1'b0);
      checkOutput("to_c300_dir", core_dir, 5'd8);
      tick;
      checkOutput("to_c301_err", err_timeout, 1'b1);
      checkOutput("to_fault_data", core_data_in, 24'h0);
      checkOutput("to_fault_dir", core_dir, 5'd0);
      tick;
      checkOutput("to_fault_hold", err_timeout, 1'b1);
      enable = 1'b0;
      tick;
      checkOutput("clr_err", err_timeout, 1'b0);
      checkOutput("clr_overrun", overrun, 1'b0);
      checkOutput("idle_start", core_start, 1'b0);

      enable = 1'b1;
      tick;
      checkOutput("re_start", core_start, 1'b1);
      tick;
      tick;
      tick;
      checkOutput("re_w0", core_data_in, KP);
      tick;
      checkOutput("re_w1", core_data_in, KI);
      tick;
      checkOutput("re_w2", core_data_in, KD);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_start", core_start, 1'b0);
      checkOutput("arst_data", core_data_in, 24'h0);
      checkOutput("arst_result", result, 24'h0);
      checkOutput("arst_rv", result_valid, 1'b0);
      checkOutput("arst_flags", {stale, err_timeout, overrun}, 3'b000);
      enable = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      checkOutput("arst_no_start", core_start, 1'b0);
      enable = 1'b1;
      tick;
      checkOutput("arst_restart", core_start, 1'b1);
      tick;
      tick;
      tick;

      loadWords("L6", 24'h000000, 24'h000000, 1'b1, 1'b0, 24'h0);
      enable = 1'b0;
      runLoop("R6", 2, 24'h005000, 1'b0);
      tick;
      checkOutput("drain_idle_start", core_start, 1'b0);
      checkOutput("drain_idle_data", core_data_in, 24'h0);
      checkOutput("drain_rv_low", result_valid, 1'b0);
      checkOutput("drain_result_hold", result, 24'h005000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
